// File: rtl/s820_resp_pkg.sv
// Shared types and default constants for the s820a response compactor.
package s820_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int          RESP_W = 19;
  localparam int          SIG_W  = 32;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED   = 32'hFFFFFFFF;

endpackage

// File: rtl/s820_misr_step.sv
// One MISR step: shift with polynomial feedback, then fold in the response word.
module s820_misr_step #(
  parameter int               SIG_W  = 32,
  parameter int               RESP_W = 19,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0]  sig_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] shifted_s;
  logic [SIG_W-1:0] resp_ext_s;

  always_comb begin
    shifted_s  = {sig_i[SIG_W-2:0], 1'b0};
    resp_ext_s = {{(SIG_W-RESP_W){1'b0}}, resp_i};
    if (sig_i[SIG_W-1]) begin
      sig_o = shifted_s ^ POLY ^ resp_ext_s;
    end else begin
      sig_o = shifted_s ^ resp_ext_s;
    end
  end

endmodule

// File: rtl/s820_resp_compactor.sv
// Compacts s820a primary outputs into a MISR signature over a programmed number of valid cycles.
// Optional expected-signature comparator enabled by defining S820_RESP_EXPECT_EN.
module s820_resp_compactor #(
  parameter int                 RESP_W = s820_resp_pkg::RESP_W,
  parameter int                 SIG_W  = s820_resp_pkg::SIG_W,
  parameter int                 CNT_W  = s820_resp_pkg::CNT_W,
  parameter logic [SIG_W-1:0]   POLY   = s820_resp_pkg::POLY,
  parameter logic [SIG_W-1:0]   SEED   = s820_resp_pkg::SEED
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
  input  logic [CNT_W-1:0]  LEN,
  input  logic              RESP_VLD,
  input  logic [RESP_W-1:0] RESP,
  output logic              BUSY,
  output logic              DONE,
  output logic [SIG_W-1:0]  SIG,
  output logic [CNT_W-1:0]  CNT,
`ifdef S820_RESP_EXPECT_EN
  input  logic [SIG_W-1:0]  EXP_SIG,
  output logic              PASS,
`endif
  input  logic              SIG_ACK
);

  import s820_resp_pkg::*;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_step_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  s820_misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr_step (
    .sig_i  (sig_q),
    .resp_i (RESP),
    .sig_o  (sig_step_s)
  );

  // Next-state, signature and counter update
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          sig_d = SEED;
          if (LEN != '0) begin
            cnt_d   = LEN;
            state_d = RUN;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      RUN: begin
        if (RESP_VLD) begin
          sig_d = sig_step_s;
          // Guarded decrement: CNT never wraps even if RUN were entered with 0
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
      end
      HOLD: begin
        if (SIG_ACK) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SIG  = sig_q;
  assign CNT  = cnt_q;

`ifdef S820_RESP_EXPECT_EN
  logic pass_q, pass_d;

  // Verdict is captured from the signature being loaded on the HOLD-entry edge
  always_comb begin
    pass_d = pass_q;
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      pass_d = (sig_d == EXP_SIG);
    end else if ((state_q == HOLD) && (state_d != HOLD)) begin
      pass_d = 1'b0;
    end else begin
      pass_d = pass_q;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign PASS = pass_q;
`endif

endmodule

// File: tb/tb_s820_resp_compactor.sv
// Scoreboard bench for s820_resp_compactor; expected signatures come from a reference MISR model.
module tb_s820_resp_compactor;

  logic        CK = 1'b0;
  logic        RN;
  logic        START;
  logic [15:0] LEN;
  logic        RESP_VLD;
  logic [18:0] RESP;
  logic        BUSY;
  logic        DONE;
  logic [31:0] SIG;
  logic [15:0] CNT;
  logic        SIG_ACK;
`ifdef S820_RESP_EXPECT_EN
  logic [31:0] EXP_SIG;
  logic        PASS;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  s820_resp_compactor dut (
    .CK       (CK),
    .RN       (RN),
    .START    (START),
    .LEN      (LEN),
    .RESP_VLD (RESP_VLD),
    .RESP     (RESP),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SIG      (SIG),
    .CNT      (CNT),
`ifdef S820_RESP_EXPECT_EN
    .EXP_SIG  (EXP_SIG),
    .PASS     (PASS),
`endif
    .SIG_ACK  (SIG_ACK)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference MISR: 33-bit polynomial reduction of the shifted signature
  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [18:0] r);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ 33'h1_04C1_1DB7;
    return t[31:0] ^ {13'd0, r};
  endfunction

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic start_run(input logic [15:0] len);
    START = 1'b1;
    LEN   = len;
`ifdef S820_RESP_EXPECT_EN
    EXP_SIG = 32'hFFFFFFFF;
`endif
    tick();
    START = 1'b0;
  endtask

  // Wait (bounded) for DONE, then pop the scoreboard and compare
  task automatic collect(input string tag, input logic pass_exp);
    int k = 0;
    while (DONE !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_cnt"}, CNT, 0);
    chk({tag, "_sig"}, SIG, exp_q.pop_front());
`ifdef S820_RESP_EXPECT_EN
    chk({tag, "_pass"}, PASS, pass_exp);
`endif
  endtask

  task automatic ack(input string tag, input logic [31:0] sig_exp);
    SIG_ACK = 1'b1;
    tick();
    SIG_ACK = 1'b0;
    chk({tag, "_ack_done"}, DONE, 0);
    chk({tag, "_ack_sig"}, SIG, sig_exp);
`ifdef S820_RESP_EXPECT_EN
    chk({tag, "_ack_pass"}, PASS, 0);
`endif
  endtask

  // Feed len valid responses (optionally with idle gaps), push the model result
  task automatic feed(input int len, input bit gaps, input string tag);
    logic [31:0] m = 32'hFFFFFFFF;
    int got = 0;
    while (got < len) begin
      RESP     = 19'($urandom);
      RESP_VLD = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (RESP_VLD) begin
        m = misr_ref(m, RESP);
        got++;
      end
`ifdef S820_RESP_EXPECT_EN
      EXP_SIG = m;
`endif
      tick();
    end
    RESP_VLD = 1'b0;
    exp_q.push_back(m);
    collect(tag, 1'b1);
    ack(tag, m);
  endtask

  task automatic one_shot(input string tag, input logic [18:0] r, input logic [31:0] sig_exp,
                          input logic [31:0] exp_drive, input logic pass_exp);
    start_run(16'd1);
    chk({tag, "_run_busy"}, BUSY, 1);
    chk({tag, "_run_cnt"}, CNT, 1);
    chk({tag, "_seed"}, SIG, 32'hFFFFFFFF);
`ifdef S820_RESP_EXPECT_EN
    EXP_SIG = exp_drive;
`endif
    RESP     = r;
    RESP_VLD = 1'b1;
    exp_q.push_back(sig_exp);
    tick();
    RESP_VLD = 1'b0;
    chk({tag, "_done_at_2"}, DONE, 1);
    collect(tag, pass_exp);
    ack(tag, sig_exp);
  endtask

  initial begin
    logic [31:0] m;
    bit   [4:0]  pat;
    logic [15:0] cnt_tab [5];
    cnt_tab = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd0};
    pat     = 5'b11001;
    RN = 1'b0; START = 1'b0; LEN = 16'd0; RESP_VLD = 1'b0; RESP = 19'd0; SIG_ACK = 1'b0;
`ifdef S820_RESP_EXPECT_EN
    EXP_SIG = 32'd0;
`endif
    #12;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sig", SIG, 0);
    chk("rst_cnt", CNT, 0);
    @(negedge CK);
    RN = 1'b1;
    tick();

    // Reset abandons a run after 4 valid cycles
    start_run(16'd10);
    RESP_VLD = 1'b1;
    repeat (4) begin
      RESP = 19'($urandom);
      tick();
    end
    chk("mid_cnt", CNT, 6);
    #2 RN = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    chk("arst_sig", SIG, 0);
    chk("arst_cnt", CNT, 0);
    RESP_VLD = 1'b0;
    @(negedge CK);
    RN = 1'b1;
    tick();
    chk("post_rst_done", DONE, 0);
    start_run(16'd5);
    feed(5, 1'b0, "after_rst");

    one_shot("len1_zero", 19'd0, 32'hFB3EE249, 32'hFB3EE249, 1'b1);
    one_shot("len1_ones", 19'h7FFFF, 32'hFB391DB6, 32'hFB391DB6, 1'b1);
    one_shot("len1_nopass", 19'h7FFFF, 32'hFB391DB6, 32'h0, 1'b0);

    // LEN=0 goes straight to HOLD without BUSY
    start_run(16'd0);
    chk("len0_busy", BUSY, 0);
    exp_q.push_back(32'hFFFFFFFF);
    collect("len0", 1'b1);
    ack("len0", 32'hFFFFFFFF);

    // LEN=3 with gapped valid pattern and stray START pulses
    start_run(16'd3);
    chk("gap_cnt0", CNT, 3);
    m = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      RESP     = 19'($urandom);
      RESP_VLD = pat[i];
      START    = (i == 1 || i == 2);
      LEN      = 16'd7;
      if (RESP_VLD) m = misr_ref(m, RESP);
`ifdef S820_RESP_EXPECT_EN
      EXP_SIG = m;
`endif
      tick();
      chk($sformatf("gap_cnt%0d", i + 1), CNT, cnt_tab[i]);
      chk($sformatf("gap_done%0d", i + 1), DONE, (i == 4));
    end
    RESP_VLD = 1'b0;
    START    = 1'b0;
    exp_q.push_back(m);
    collect("gap", 1'b1);

    // HOLD stays stable without ACK; ACK with START drops the START
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_done", DONE, 1);
      chk("hold_sig", SIG, m);
    end
    SIG_ACK = 1'b1;
    START   = 1'b1;
    LEN     = 16'd4;
    tick();
    SIG_ACK = 1'b0;
    START   = 1'b0;
    chk("ackstart_done", DONE, 0);
    chk("ackstart_busy", BUSY, 0);
    chk("ackstart_sig", SIG, m);
    tick();
    chk("idle_stays", BUSY, 0);
    start_run(16'd2);
    chk("restart_busy", BUSY, 1);
    chk("restart_cnt", CNT, 2);
    chk("restart_seed", SIG, 32'hFFFFFFFF);
    feed(2, 1'b0, "restart");

    for (int r = 0; r < 4; r++) begin
      start_run(16'(r + 3));
      feed(r + 3, 1'b1, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
